div: RTL

- Multi-cycle 32-bit integer divider; the responder for DIV/DIVU requests issued by the execute stage.
- EX raises start_i with operands and holds it until ready_o. The divider returns {remainder, quotient}, which EX writes to HI/LO through whilo_o.
- Radix-2 restoring algorithm, one quotient bit per clock, with signed-operand pre- and post-correction.
- Sits beside ex; EX stalls the pipeline while a request is outstanding.

---
 rtl/div.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div - multi-cycle 32-bit integer divider (DIV / DIVU responder for EX)
//
// Radix-2 restoring division, one quotient bit per clock. Signed requests are
// reduced to magnitudes at capture and the signs are restored when the
// iterations finish.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o is seen
//   annul_i       cancels the in-flight operation
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// Build option:
//   DIV_FAST_EN   when defined, a request whose dividend magnitude is below the
//                 divisor magnitude finishes on the edge after capture.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// DIV_FREE     | idle, outputs 0, waits for start_i without annul_i
// DIV_BY_ZERO  | divisor was 0, result 0 presented on the next edge
// DIV_ON       | shifting/subtracting one quotient bit per edge
// DIV_END      | result held while start_i stays high
// ---------------------------------------------------------------------------
module div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [1:0] DIV_FREE    = 2'd0;
  localparam logic [1:0] DIV_BY_ZERO = 2'd1;
  localparam logic [1:0] DIV_ON      = 2'd2;
  localparam logic [1:0] DIV_END     = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  // {remainder, quotient}; the bit shifted out of the top feeds the trial
  // subtraction, which makes this the 65-bit partial without storing bit 64.
  logic [2*DATA_W-1:0] r_work;
  logic [DATA_W-1:0]   r_divisor;
  // Sign flags are only set for signed requests, so they double as the
  // "correction needed" indicators.
  logic                r_neg1;
  logic                r_neg2;

  logic                w_neg1;
  logic                w_neg2;
  logic [DATA_W-1:0]   w_mag1;
  logic [DATA_W-1:0]   w_mag2;
  logic                w_fast;
  logic [2*DATA_W:0]   w_shift;
  logic [DATA_W:0]     w_trial;
  logic                w_ge;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic                w_stop;

  assign w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
  assign w_mag1 = w_neg1 ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
  assign w_mag2 = w_neg2 ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

`ifdef DIV_FAST_EN
  assign w_fast = (w_mag1 < w_mag2);
`else
  assign w_fast = 1'b0;
`endif

  assign w_shift = {r_work, 1'b0};
  assign w_trial = w_shift[2*DATA_W:DATA_W] - {1'b0, r_divisor};
  // A set shifted-out bit means the upper part is >= 2^DATA_W, always above
  // the divisor; otherwise the borrow of the 33-bit subtraction decides.
  assign w_ge    = w_shift[2*DATA_W] | ~w_trial[DATA_W];

  assign w_quot     = r_work[DATA_W-1:0];
  assign w_rem      = r_work[2*DATA_W-1:DATA_W];
  assign w_quot_fix = (r_neg1 ^ r_neg2) ? (~w_quot + DATA_W'(1)) : w_quot;
  assign w_rem_fix  = r_neg1 ? (~w_rem + DATA_W'(1)) : w_rem;

  assign w_stop = annul_i | ~start_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      ready_o   <= 1'b0;
      result_o  <= '0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_divisor <= w_mag2;
              r_neg1    <= w_neg1;
              r_neg2    <= w_neg2;
              r_state   <= DIV_ON;
              if (w_fast) begin
                // Quotient is 0 and the remainder is the dividend magnitude:
                // preload the finished partial and skip straight to the
                // finish edge, which restores the signs as usual.
                r_work <= {w_mag1, {DATA_W{1'b0}}};
                r_cnt  <= CNT_LAST;
              end else begin
                r_work <= {{DATA_W{1'b0}}, w_mag1};
                r_cnt  <= '0;
              end
            end
          end
        end

        DIV_BY_ZERO: begin
          r_state  <= DIV_END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end

        DIV_ON: begin
          if (w_stop) begin
            r_state  <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (r_cnt != CNT_LAST) begin
            if (w_ge) begin
              r_work <= {w_trial[DATA_W-1:0], w_shift[DATA_W-1:1], 1'b1};
            end else begin
              r_work <= w_shift[2*DATA_W-1:0];
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_state  <= DIV_END;
            ready_o  <= 1'b1;
            result_o <= {w_rem_fix, w_quot_fix};
          end
        end

        DIV_END: begin
          if (w_stop) begin
            r_state  <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: begin
          r_state  <= DIV_FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule
